// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multi-cycle integer divider, restoring shift/subtract, one
//             quotient bit per clock, start/busy/done handshake. Signed or
//             unsigned operands; reports divide-by-zero and signed overflow.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1      clock, rising edge
//    rst            in   1      synchronous active-high reset
//    start_i        in   1      request, honoured only when not busy
//    signed_mode_i  in   1      1: two's-complement operands, 0: unsigned
//    dividend_i     in   WIDTH  numerator, captured on accepted start
//    divisor_i      in   WIDTH  denominator, captured on accepted start
//    busy_o         out  1      division loop / sign fix in progress
//    done_o         out  1      one-cycle pulse, results valid
//    quotient_o     out  WIDTH  quotient, held until next result
//    remainder_o    out  WIDTH  remainder, held until next result
//    error_o        out  2      00 ok, 01 divide-by-zero, 10 signed overflow
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic [1:0]       error_o
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0]       ERR_NONE  = 2'b00;
    localparam logic [1:0]       ERR_DIV0  = 2'b01;
    localparam logic [1:0]       ERR_OVF   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] acc_q,   acc_d;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   prem_q,  prem_d;   // partial remainder with carry bit
    logic [WIDTH-1:0] dvs_q,   dvs_d;    // divisor magnitude
    logic             qneg_q,  qneg_d;
    logic             rneg_q,  rneg_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [1:0]       err_q,   err_d;

    // Operand decode for the accept cycle
    logic             w_dvd_neg, w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
    logic             w_div0, w_ovf;

    assign w_dvd_neg = signed_mode_i & dividend_i[WIDTH-1];
    assign w_dvs_neg = signed_mode_i & divisor_i[WIDTH-1];
    // MIN negates to itself, which is exactly its unsigned magnitude.
    assign w_dvd_mag = w_dvd_neg ? -dividend_i : dividend_i;
    assign w_dvs_mag = w_dvs_neg ? -divisor_i  : divisor_i;
    assign w_div0    = (divisor_i == '0);
    assign w_ovf     = signed_mode_i && (dividend_i == MIN_VAL) && (divisor_i == '1);

    // One restoring step: bring in the next dividend bit, try the subtract.
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    assign w_shift = {prem_q, acc_q[WIDTH-1]};
    assign w_fits  = (w_shift >= {2'b00, dvs_q});
    assign w_diff  = w_shift[WIDTH:0] - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    // Divide-by-zero has priority over overflow.
                    if (w_div0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend_i;
                        err_d   = ERR_DIV0;
                    end else if (w_ovf) begin
                        state_d = S_DONE;
                        quot_d  = MIN_VAL;
                        rem_d   = '0;
                        err_d   = ERR_OVF;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        acc_d   = w_dvd_mag;
                        prem_d  = '0;
                        dvs_d   = w_dvs_mag;
                        qneg_d  = w_dvd_neg ^ w_dvs_neg;
                        rneg_d  = w_dvd_neg;
                    end
                end
            end
            S_CALC: begin
                acc_d  = {acc_q[WIDTH-2:0], w_fits};
                prem_d = w_fits ? w_diff : w_shift[WIDTH:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Truncation toward zero: quotient sign from operand signs,
                // remainder sign follows the dividend.
                state_d = S_DONE;
                quot_d  = qneg_q ? -acc_q : acc_q;
                rem_d   = rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
                err_d   = ERR_NONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done_o      = (state_q == S_DONE);
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign error_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider (WIDTH=16): directed vector
//             table, hand-written handshake/reset sequences, and randomized
//             operations checked against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    localparam int W       = 16;
    localparam int LAT_RUN = W + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic [1:0]    err;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .signed_mode_i (signed_mode),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .error_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         sm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [1:0]   e;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic plus the special-case rules.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic [1:0] e, output int lat);
        int sa, sb;
        if (b == 0) begin
            q = '1; r = a; e = 2'b01; lat = 1;
        end else if (sm && a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000; r = '0; e = 2'b10; lat = 1;
        end else begin
            if (sm) begin
                sa = $signed(a);
                sb = $signed(b);
            end else begin
                sa = {16'b0, a};
                sb = {16'b0, b};
            end
            q = 16'(sa / sb);
            r = 16'(sa % sb);
            e = 2'b00;
            lat = LAT_RUN;
        end
    endtask

    // Called right after the accepting edge (#1 later). Counts cycles to done,
    // checks busy on the way, and returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int lat_exp);
        int  k;
        bit  seen;
        int  busy_bad;
        k = 0; seen = 0; busy_bad = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) seen = 1;
            else if (busy !== (lat_exp > 1)) busy_bad++;
        end
        check({tag, "_latency"}, k, lat_exp);
        check({tag, "_busy_trace"}, busy_bad, 0);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic [1:0] ee, input int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; signed_mode = sm;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom); signed_mode = 1'($urandom);
        wait_done(tag, lat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_error"}, err, ee);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_quotient_held"}, quotient, eq);
    endtask

    initial begin
        logic [W-1:0] mq, mr, a, b;
        logic [1:0]   me;
        int           ml, sel, dones, first_done;
        logic         sm;

        vecs[0]  = '{16'd100,   16'd7,     1'b0, 16'd14,    16'd2,     2'b00, LAT_RUN};
        vecs[1]  = '{16'hFFF9,  16'h0002,  1'b1, 16'hFFFD,  16'hFFFF,  2'b00, LAT_RUN};
        vecs[2]  = '{16'h0007,  16'hFFFE,  1'b1, 16'hFFFD,  16'h0001,  2'b00, LAT_RUN};
        vecs[3]  = '{16'hFFF9,  16'h0002,  1'b0, 16'h7FFC,  16'h0001,  2'b00, LAT_RUN};
        vecs[4]  = '{16'd5,     16'd0,     1'b0, 16'hFFFF,  16'd5,     2'b01, 1};
        vecs[5]  = '{16'd5,     16'd0,     1'b1, 16'hFFFF,  16'd5,     2'b01, 1};
        vecs[6]  = '{16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'h0000,  2'b10, 1};
        vecs[7]  = '{16'h8000,  16'hFFFF,  1'b0, 16'h0000,  16'h8000,  2'b00, LAT_RUN};
        vecs[8]  = '{16'h8000,  16'h0001,  1'b1, 16'h8000,  16'h0000,  2'b00, LAT_RUN};
        vecs[9]  = '{16'hFFFF,  16'hFFFF,  1'b0, 16'h0001,  16'h0000,  2'b00, LAT_RUN};
        vecs[10] = '{16'h0000,  16'h0005,  1'b1, 16'h0000,  16'h0000,  2'b00, LAT_RUN};
        vecs[11] = '{16'h8000,  16'h0000,  1'b1, 16'hFFFF,  16'h8000,  2'b01, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_error", err, 0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].sm,
                  vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].lat);
        end

        // Start pulses while busy are dropped; single done with 1000/3 result
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3; signed_mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        dones = 0; first_done = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first_done == 0) begin
                    first_done = c;
                    check("ignore_quotient", quotient, 333);
                    check("ignore_remainder", remainder, 1);
                    check("ignore_error", err, 0);
                end
            end
            if (c == 3 || c == 10) begin
                start = 1'b1; dividend = 16'h1234; divisor = 16'h0000; signed_mode = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore_done_cycle", first_done, LAT_RUN);
        check("ignore_done_count", dones, 1);

        // Back-to-back: start held in the DONE cycle is accepted
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 16'd7; signed_mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        wait_done("b2b_first", LAT_RUN);
        start = 1'b1; dividend = 16'd50; divisor = 16'd6; signed_mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        wait_done("b2b_second", LAT_RUN);
        check("b2b_quotient", quotient, 8);
        check("b2b_remainder", remainder, 2);
        check("b2b_error", err, 0);

        // Reset mid-CALC abandons the operation
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3; signed_mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_error", err, 0);
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst_no_done", dones, 0);
        do_op("after_rst", 16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 2'b00, LAT_RUN);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sm  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = '0;
            else if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; end
            else if (sel == 2) b = W'($urandom_range(1, 15));
            else if (sel == 3) b = W'(-$urandom_range(1, 15));
            model(a, b, sm, mq, mr, me, ml);
            do_op($sformatf("rand%0d", i), a, b, sm, mq, mr, me, ml);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
